// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - state_t       : fetch FSM encoding (FETCH, HOLD)
//   - *_MSB         : instruction field positions inside the IR
//   - RESET_PC_DEFAULT : PC loaded on reset unless overridden
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Instruction field positions (16-bit instruction word)
    localparam int OPC_MSB  = 15;   // opcode  = ir[15:12]
    localparam int RS_MSB   = 11;   // rs      = ir[11:8]
    localparam int RT_MSB   = 7;    // rt      = ir[7:4]
    localparam int BOFF_MSB = 3;    // branch offset = ir[3:0]

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory request/acknowledge bus.
//   Ports (signals):
//     mem_req   : fetch request, driven by the fetch unit
//     mem_addr  : word address of the fetch
//     mem_ack   : memory returns mem_rdata valid this cycle
//     mem_rdata : fetched instruction word
//
//   Handshake: a transfer happens on a rising clock edge where mem_req and
//   mem_ack are both 1. Once raised, mem_req and mem_addr stay stable until
//   that edge. mem_ack is only meaningful while mem_req is 1; an ack seen
//   with mem_req low is ignored.
//   Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   mem_req;
    logic [PC_WIDTH-1:0]    mem_addr;
    logic                   mem_ack;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
//   Combinational next-PC selection for the fetch stage.
//   Ports:
//     pc            : address of the held instruction
//     ir            : low 12 bits of the held instruction (jump target /
//                     branch offset field); the opcode is not needed here
//     jump_en       : absolute jump -> {pc[15:12], ir[11:0]}
//     branch_en     : conditional branch
//     branch_decide : comparator result, only used when branch_en = 1
//     next_pc       : selected next PC (modulo 2^PC_WIDTH)
// ---------------------------------------------------------------------------
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [11:0]         ir,
    input  logic                jump_en,
    input  logic                branch_en,
    input  logic                branch_decide,
    output logic [PC_WIDTH-1:0] next_pc
);

    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_boff_sext;
    logic [PC_WIDTH-1:0] w_jump_tgt;

    assign w_pc_inc    = pc + PC_WIDTH'(1);
    // 4-bit signed word offset, range -8..+7, relative to pc + 1
    assign w_boff_sext = {{(PC_WIDTH-BOFF_MSB-1){ir[BOFF_MSB]}}, ir[BOFF_MSB:0]};
    // Jump keeps the current 4K-word page and replaces the low 12 bits
    assign w_jump_tgt  = {pc[PC_WIDTH-1:12], ir[11:0]};

    always_comb begin
        next_pc = w_pc_inc;
        if (jump_en) begin
            next_pc = w_jump_tgt;
        end else if (branch_en && branch_decide) begin
            next_pc = w_pc_inc + w_boff_sext;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of the 16-bit multicycle datapath. Fetches one
//   instruction per memory handshake into the IR, presents its fields to the
//   register file / immediate path, and steps the PC when downstream reports
//   the instruction done.
//
//   Ports:
//     clock, reset_n  : clock, asynchronous active-low reset
//     mem             : instruction-memory bus (fetch_unit_if.master)
//     instr_valid     : IR holds an instruction awaiting completion
//     opcode/rs/rt    : ir[15:12] / ir[11:8] / ir[7:4]
//     imm12           : ir[11:0]
//     pc              : address of current / being-fetched instruction
//     instr_done      : downstream finished the held instruction
//     branch_en, branch_decide, jump_en : next-PC controls
//     dbg_state       : current FSM state
//     retire_count    : saturating completed-instruction counter
//                       (present only when FETCH_RETIRE_COUNT_EN is defined)
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                clock,
    input  logic                reset_n,
    fetch_unit_if.master        mem,
    output logic                instr_valid,
    output logic [3:0]          opcode,
    output logic [3:0]          rs,
    output logic [3:0]          rt,
    output logic [11:0]         imm12,
    output logic [PC_WIDTH-1:0] pc,
    input  logic                instr_done,
    input  logic                branch_en,
    input  logic                branch_decide,
    input  logic                jump_en,
`ifdef FETCH_RETIRE_COUNT_EN
    output logic [15:0]         retire_count,
`endif
    output state_t              dbg_state
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic [PC_WIDTH-1:0]    w_next_pc;
    logic                   w_fetch_take;
    logic                   w_retire;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        mem.mem_req  = 1'b0;
        instr_valid  = 1'b0;
        w_fetch_take = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            FETCH: begin
                // Gated with reset_n so the request drops the moment reset
                // asserts, not only once the state register has settled.
                mem.mem_req  = reset_n;
                w_fetch_take = mem.mem_ack;
                if (mem.mem_ack) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                w_retire    = instr_done;
                if (instr_done) begin
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // PC and IR. The IR only loads on a FETCH-state ack, so acks arriving in
    // HOLD leave it untouched; the PC only moves on a HOLD-state completion.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
        end else begin
            if (w_fetch_take) begin
                r_ir <= mem.mem_rdata;
            end
            if (w_retire) begin
                r_pc <= w_next_pc;
            end
        end
    end

    next_pc_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_pc_calc (
        .pc            (r_pc),
        .ir            (r_ir[11:0]),
        .jump_en       (jump_en),
        .branch_en     (branch_en),
        .branch_decide (branch_decide),
        .next_pc       (w_next_pc)
    );

`ifdef FETCH_RETIRE_COUNT_EN
    logic [15:0] r_retire_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_retire_count <= '0;
        end else if (w_retire && (r_retire_count != 16'hFFFF)) begin
            r_retire_count <= r_retire_count + 16'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

    assign mem.mem_addr = r_pc;
    assign pc           = r_pc;
    assign opcode       = r_ir[OPC_MSB:OPC_MSB-3];
    assign rs           = r_ir[RS_MSB:RS_MSB-3];
    assign rt           = r_ir[RT_MSB:RT_MSB-3];
    assign imm12        = r_ir[11:0];
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Inputs change 1 time unit after the rising
//   edge; outputs are sampled away from the edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_pkg::*;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // DUT signals
  fetch_unit_if #(.PC_WIDTH(16), .INSTR_WIDTH(16)) mem_bus ();
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [11:0] imm12;
  logic [15:0] pc;
  logic        instr_done = 1'b0;
  logic        branch_en = 1'b0;
  logic        branch_decide = 1'b0;
  logic        jump_en = 1'b0;
  state_t      dbg_state;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [15:0] retire_count;
`endif

  fetch_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .mem           (mem_bus),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .imm12         (imm12),
    .pc            (pc),
    .instr_done    (instr_done),
    .branch_en     (branch_en),
    .branch_decide (branch_decide),
    .jump_en       (jump_en),
`ifdef FETCH_RETIRE_COUNT_EN
    .retire_count  (retire_count),
`endif
    .dbg_state     (dbg_state)
  );

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Ack the pending fetch in its first request cycle.
  task automatic fetch_word(input logic [15:0] word);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = word;
    step();
    mem_bus.mem_ack   = 1'b0;
    check_eq("fetch_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  // Complete the held instruction with the given next-PC controls.
  task automatic complete(input logic jmp, input logic br, input logic dec);
    instr_done    = 1'b1;
    jump_en       = jmp;
    branch_en     = br;
    branch_decide = dec;
    step();
    instr_done    = 1'b0;
    jump_en       = 1'b0;
    branch_en     = 1'b0;
    branch_decide = 1'b0;
  endtask

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 16'h0000;

    // ---- reset state ----
    step();
    step();
    check_eq("rst_req",   {31'd0, mem_bus.mem_req}, 32'd0);
    check_eq("rst_pc",    {16'd0, pc}, 32'h0000);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_imm",   {20'd0, imm12}, 32'h000);
    reset_n = 1'b1;
    #1;
    check_eq("rel_req",   {31'd0, mem_bus.mem_req}, 32'd1);
    check_eq("rel_addr",  {16'd0, mem_bus.mem_addr}, 32'h0000);
    check_eq("rel_state", {31'd0, dbg_state}, {31'd0, FETCH});
`ifdef FETCH_RETIRE_COUNT_EN
    check_eq("rst_retire", {16'd0, retire_count}, 32'd0);
`endif

    // ---- 1: immediate ack of 16'h1234 ----
    fetch_word(16'h1234);
    check_eq("t1_opcode", {28'd0, opcode}, 32'h1);
    check_eq("t1_rs",     {28'd0, rs}, 32'h2);
    check_eq("t1_rt",     {28'd0, rt}, 32'h3);
    check_eq("t1_imm12",  {20'd0, imm12}, 32'h234);
    check_eq("t1_req",    {31'd0, mem_bus.mem_req}, 32'd0);
    complete(1'b0, 1'b0, 1'b0);
    check_eq("t1_pc",     {16'd0, pc}, 32'h0001);
    check_eq("t1_refetch", {31'd0, mem_bus.mem_req}, 32'd1);

    // ---- 2: ack delayed 3 cycles; instr_done in FETCH ignored ----
    for (int i = 0; i < 3; i++) begin
      instr_done = (i == 1);
      step();
      instr_done = 1'b0;
      check_eq("t2_wait_req",  {31'd0, mem_bus.mem_req}, 32'd1);
      check_eq("t2_wait_addr", {16'd0, mem_bus.mem_addr}, 32'h0001);
      check_eq("t2_wait_vld",  {31'd0, instr_valid}, 32'd0);
    end
    fetch_word(16'hABCD);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 16'h5555;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("t2_hold_opc", {28'd0, opcode}, 32'hA);
      check_eq("t2_hold_imm", {20'd0, imm12}, 32'hBCD);
      check_eq("t2_hold_vld", {31'd0, instr_valid}, 32'd1);
    end
    mem_bus.mem_ack = 1'b0;
    complete(1'b0, 1'b0, 1'b0);
    check_eq("t2_pc", {16'd0, pc}, 32'h0002);

    // ---- 3: branch at pc 0x0010 with offset -2 ----
    fetch_word(16'h0010);
    complete(1'b1, 1'b0, 1'b0);
    check_eq("t3_jmp_pc", {16'd0, pc}, 32'h0010);
    fetch_word(16'h000E);
    complete(1'b0, 1'b1, 1'b1);
    check_eq("t3_taken_addr", {16'd0, mem_bus.mem_addr}, 32'h000F);
    fetch_word(16'h0010);
    complete(1'b1, 1'b0, 1'b0);
    fetch_word(16'h000E);
    complete(1'b0, 1'b1, 1'b0);
    check_eq("t3_not_taken", {16'd0, mem_bus.mem_addr}, 32'h0011);
    fetch_word(16'h000E);
    complete(1'b0, 1'b0, 1'b1);
    check_eq("t3_decide_no_en", {16'd0, pc}, 32'h0012);

    // ---- 4: climb to 0x5000, then jump+branch together ----
    for (int n = 0; n < 5; n++) begin
      fetch_word(16'h0FFF);
      complete(1'b1, 1'b0, 1'b0);
      fetch_word(16'h0000);
      complete(1'b0, 1'b0, 1'b0);
    end
    check_eq("t4_pc_5000", {16'd0, pc}, 32'h5000);
    fetch_word(16'hFABC);
    complete(1'b1, 1'b1, 1'b1);
    check_eq("t4_jump_prio", {16'd0, pc}, 32'h5ABC);

    // ---- 5: climb to 0xFFFF and wrap ----
    for (int n = 5; n < 15; n++) begin
      fetch_word(16'h0FFF);
      complete(1'b1, 1'b0, 1'b0);
      fetch_word(16'h0000);
      complete(1'b0, 1'b0, 1'b0);
    end
    check_eq("t5_pc_f000", {16'd0, pc}, 32'hF000);
    fetch_word(16'h0FFF);
    complete(1'b1, 1'b0, 1'b0);
    check_eq("t5_pc_ffff", {16'd0, pc}, 32'hFFFF);
    fetch_word(16'h0000);
    complete(1'b0, 1'b0, 1'b0);
    check_eq("t5_wrap", {16'd0, pc}, 32'h0000);

    // ---- 6: reset mid-fetch with an ack pending ----
    fetch_word(16'h0042);
    complete(1'b1, 1'b0, 1'b0);
    check_eq("t6_pc_42", {16'd0, mem_bus.mem_addr}, 32'h0042);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 16'hDEAD;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_req_drop", {31'd0, mem_bus.mem_req}, 32'd0);
    check_eq("t6_pc_rst",   {16'd0, pc}, 32'h0000);
    check_eq("t6_vld_rst",  {31'd0, instr_valid}, 32'd0);
    step();
    reset_n         = 1'b1;
    mem_bus.mem_ack = 1'b0;
    #1;
    check_eq("t6_req_back", {31'd0, mem_bus.mem_req}, 32'd1);
    check_eq("t6_addr",     {16'd0, mem_bus.mem_addr}, 32'h0000);
    check_eq("t6_ir_clr",   {20'd0, imm12}, 32'h000);
    step();
    check_eq("t6_still_fetch", {31'd0, dbg_state}, {31'd0, FETCH});

`ifdef FETCH_RETIRE_COUNT_EN
    check_eq("t6_retire0", {16'd0, retire_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      fetch_word(16'h0000);
      complete(1'b0, 1'b0, 1'b0);
    end
    check_eq("t6_retire3", {16'd0, retire_count}, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
